conv_seq_engine: RTL and testbench

Parametrised sequential 2-D convolution engine. It computes a full valid-mode convolution of an N×N signed input tile with a K×K signed filter, one multiply-accumulate per clock, and produces an M×M output tile (M = N−K+1). It replaces the fixed 4×4/3×3, 8-bit, state-per-tap engine in the computation layer. Additions over that engine: a start/busy/done handshake, input capture, signed saturation and generic sizes.

---
 rtl/conv_seq_engine_if.sv | 25 ++
 rtl/conv_seq_engine.sv | 151 +++++++++++++++
 tb/tb_conv_seq_engine.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_engine_if.sv
// Handshake and tile bus between a convolution requester and conv_seq_engine.
interface conv_seq_engine_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 3
);
    localparam int unsigned M = N - K + 1;

    logic                  start_i;
    logic [N*N*DW-1:0]     ifmap_i;
    logic [K*K*DW-1:0]     filter_i;
    logic                  busy_o;
    logic                  done_o;
    logic [M*M*DW-1:0]     ofmap_o;

    modport master (
        output start_i, ifmap_i, filter_i,
        input  busy_o, done_o, ofmap_o
    );

    modport slave (
        input  start_i, ifmap_i, filter_i,
        output busy_o, done_o, ofmap_o
    );
endinterface

// File: rtl/conv_seq_engine.sv
// Sequential valid-mode 2-D convolution, one MAC per clock, saturating output.
// Optional ReLU on written results: define CONV_SEQ_RELU_EN.
module conv_seq_engine #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 3
) (
    input  logic                clk,
    input  logic                rst,
    conv_seq_engine_if.slave    bus
);
    localparam int unsigned M   = N - K + 1;
    localparam int unsigned AW  = 2 * DW + $clog2(K * K);
    localparam int unsigned MCW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned KCW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned NIW = (N > 1) ? $clog2(N) : 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] RES_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] RES_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state, state_n;
    logic   busy_q, done_q;

    logic signed [DW-1:0] ifm [N][N];
    logic signed [DW-1:0] flt [K][K];
    logic signed [DW-1:0] ofm [M][M];
    logic signed [AW-1:0] acc;
    logic [MCW-1:0]       orow, ocol;
    logic [KCW-1:0]       kr, kc;

    logic                   last_kc, last_tap, last_col, last_row;
    logic [NIW-1:0]         wr, wc;
    logic [KCW-1:0]         fr, fc;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc_sum;
    logic signed [DW-1:0]   res;
    logic [M*M*DW-1:0]      ofmap_flat;

    // Window tap, flipped filter tap, and the saturated result of this tap
    always_comb begin
        last_kc  = (kc == KCW'(K - 1));
        last_tap = last_kc && (kr == KCW'(K - 1));
        last_col = (ocol == MCW'(M - 1));
        last_row = (orow == MCW'(M - 1));
        wr       = NIW'(orow) + NIW'(kr);
        wc       = NIW'(ocol) + NIW'(kc);
        fr       = KCW'(K - 1) - kr;
        fc       = KCW'(K - 1) - kc;
        prod     = (2*DW)'(ifm[wr][wc]) * (2*DW)'(flt[fr][fc]);
        acc_sum  = acc + AW'(prod);
        if (acc_sum > SAT_MAX)      res = RES_MAX;
        else if (acc_sum < SAT_MIN) res = RES_MIN;
        else                        res = acc_sum[DW-1:0];
`ifdef CONV_SEQ_RELU_EN
        if (res[DW-1]) res = '0;
`endif
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start_i) state_n = MAC;
            MAC:     if (last_tap && last_row && last_col) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they leave as flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == MAC);
            done_q <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            orow <= '0;
            ocol <= '0;
            kr   <= '0;
            kc   <= '0;
            for (int r = 0; r < int'(N); r++)
                for (int c = 0; c < int'(N); c++) ifm[r][c] <= '0;
            for (int r = 0; r < int'(K); r++)
                for (int c = 0; c < int'(K); c++) flt[r][c] <= '0;
            for (int r = 0; r < int'(M); r++)
                for (int c = 0; c < int'(M); c++) ofm[r][c] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    for (int r = 0; r < int'(N); r++)
                        for (int c = 0; c < int'(N); c++)
                            ifm[r][c] <= bus.ifmap_i[(r*int'(N)+c)*int'(DW) +: DW];
                    for (int r = 0; r < int'(K); r++)
                        for (int c = 0; c < int'(K); c++)
                            flt[r][c] <= bus.filter_i[(r*int'(K)+c)*int'(DW) +: DW];
                    acc  <= '0;
                    orow <= '0;
                    ocol <= '0;
                    kr   <= '0;
                    kc   <= '0;
                end
                MAC: begin
                    if (last_tap) begin
                        ofm[orow][ocol] <= res;
                        acc <= '0;
                        kr  <= '0;
                        kc  <= '0;
                        if (last_col) begin
                            ocol <= '0;
                            orow <= last_row ? '0 : orow + MCW'(1);
                        end else begin
                            ocol <= ocol + MCW'(1);
                        end
                    end else begin
                        acc <= acc_sum;
                        if (last_kc) begin
                            kc <= '0;
                            kr <= kr + KCW'(1);
                        end else begin
                            kc <= kc + KCW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ofmap_flat = '0;
        for (int r = 0; r < int'(M); r++)
            for (int c = 0; c < int'(M); c++)
                ofmap_flat[(r*int'(M)+c)*int'(DW) +: DW] = ofm[r][c];
    end

    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.ofmap_o = ofmap_flat;
endmodule

// File: tb/tb_conv_seq_engine.sv
// Directed bench for conv_seq_engine: defaults plus a DW=16, N=5, K=2 instance.
module tb_conv_seq_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    conv_seq_engine_if #(.DW(8),  .N(4), .K(3)) bus  ();
    conv_seq_engine_if #(.DW(16), .N(5), .K(2)) bus2 ();

    conv_seq_engine #(.DW(8),  .N(4), .K(3)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    conv_seq_engine #(.DW(16), .N(5), .K(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then observe cycles T+1.. until done (bounded)
    task automatic run_default(output int lat, output int bcnt);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int j = 1; j <= 100; j++) begin
            if (bus.busy_o) bcnt++;
            if (bus.done_o) begin
                lat = j;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
        checks++; if (bus.ofmap_o !== '0) begin errors++; $display("FAIL reset_ofmap got=%h exp=0", bus.ofmap_o); end
        checks++; if (bus2.ofmap_o !== '0) begin errors++; $display("FAIL reset_ofmap2 got=%h exp=0", bus2.ofmap_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ones();
        int lat, bcnt;
        bus.ifmap_i  = {16{8'd1}};
        bus.filter_i = {9{8'd1}};
        run_default(lat, bcnt);
        checks++; if (lat !== 37) begin errors++; $display("FAIL ones_latency got=%0d exp=37", lat); end
        checks++; if (bcnt !== 36) begin errors++; $display("FAIL ones_busy_cycles got=%0d exp=36", bcnt); end
        tick();
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL ones_done_width got=%b exp=0", bus.done_o); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ofmap_o[i*8 +: 8] !== 8'd9) begin
                errors++; $display("FAIL ones_out%0d got=%h exp=09", i, bus.ofmap_o[i*8 +: 8]);
            end
        end
    endtask

    task automatic test_flip();
        int lat, bcnt;
        logic [7:0] exp_v;
        bus.ifmap_i        = '0;
        bus.ifmap_i[7:0]   = 8'd5;
        bus.filter_i       = '0;
        bus.filter_i[71:64] = 8'd3;
        run_default(lat, bcnt);
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_v = (i == 0) ? 8'd15 : 8'd0;
            checks++;
            if (bus.ofmap_o[i*8 +: 8] !== exp_v) begin
                errors++; $display("FAIL flip_out%0d got=%h exp=%h", i, bus.ofmap_o[i*8 +: 8], exp_v);
            end
        end
        bus.filter_i      = '0;
        bus.filter_i[7:0] = 8'd3;
        run_default(lat, bcnt);
        tick();
        checks++; if (bus.ofmap_o !== '0) begin errors++; $display("FAIL flip_unflipped got=%h exp=0", bus.ofmap_o); end
    endtask

    task automatic test_saturation();
        int lat, bcnt;
        logic [7:0] exp_neg;
        bus.ifmap_i  = {16{8'd127}};
        bus.filter_i = {9{8'd127}};
        run_default(lat, bcnt);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ofmap_o[i*8 +: 8] !== 8'h7F) begin
                errors++; $display("FAIL sat_pos_out%0d got=%h exp=7f", i, bus.ofmap_o[i*8 +: 8]);
            end
        end
`ifdef CONV_SEQ_RELU_EN
        exp_neg = 8'h00;
`else
        exp_neg = 8'hF7;
`endif
        bus.ifmap_i  = {16{8'd1}};
        bus.filter_i = {9{8'hFF}};
        run_default(lat, bcnt);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ofmap_o[i*8 +: 8] !== exp_neg) begin
                errors++; $display("FAIL sat_neg_out%0d got=%h exp=%h", i, bus.ofmap_o[i*8 +: 8], exp_neg);
            end
        end
    endtask

    task automatic test_handshake();
        int first_done = -1;
        int done_cnt   = 0;
        bus.ifmap_i  = {16{8'd1}};
        bus.filter_i = {9{8'd1}};
        bus.start_i  = 1'b1;
        tick();
        for (int j = 1; j <= 60; j++) begin
            if (bus.done_o) begin
                done_cnt++;
                if (first_done < 0) first_done = j;
            end
            if (j == 2) bus.ifmap_i = {16{8'd2}};
            bus.start_i = (j == 5 || j == 20);
            tick();
        end
        bus.start_i = 1'b0;
        checks++; if (first_done !== 37) begin errors++; $display("FAIL hs_latency got=%0d exp=37", first_done); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL hs_done_count got=%0d exp=1", done_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.ofmap_o[i*8 +: 8] !== 8'd9) begin
                errors++; $display("FAIL hs_capture_out%0d got=%h exp=09", i, bus.ofmap_o[i*8 +: 8]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_done = -1;
        bit found = 1'b0;
        bus.ifmap_i  = {16{8'd1}};
        bus.filter_i = {9{8'd1}};
        bus.start_i  = 1'b1;
        tick();
        for (int j = 1; j <= 45; j++) begin
            if (bus.done_o && first_done < 0) first_done = j;
            if (j == 38) begin
                checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got=%b exp=0", bus.busy_o); end
            end
            if (j == 39) begin
                checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise got=%b exp=1", bus.busy_o); end
            end
            tick();
        end
        bus.start_i = 1'b0;
        checks++; if (first_done !== 37) begin errors++; $display("FAIL b2b_latency got=%0d exp=37", first_done); end
        for (int j = 0; j < 100; j++) begin
            if (bus.done_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", found); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        bus.ifmap_i         = '0;
        bus.ifmap_i[7:0]    = 8'd5;
        bus.filter_i        = '0;
        bus.filter_i[71:64] = 8'd3;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int j = 1; j < 10; j++) tick();
        rst = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", bus.done_o); end
        checks++; if (bus.ofmap_o !== '0) begin errors++; $display("FAIL rstmid_ofmap got=%h exp=0", bus.ofmap_o); end
        rst = 1'b0;
        tick();
        run_default(lat, bcnt);
        checks++; if (lat !== 37) begin errors++; $display("FAIL rstmid_rerun_latency got=%0d exp=37", lat); end
        tick();
        checks++; if (bus.ofmap_o !== 32'h0000_000F) begin errors++; $display("FAIL rstmid_rerun_ofmap got=%h exp=0000000f", bus.ofmap_o); end
    endtask

    task automatic test_sweep();
        int xs [5][5];
        int fs [2][2];
        longint sum;
        logic [15:0] exp_v;
        int lat = -1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                xs[r][c] = int'(shortint'($urandom));
                bus2.ifmap_i[(r*5+c)*16 +: 16] = 16'(xs[r][c]);
            end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                fs[r][c] = int'(shortint'($urandom_range(0, 65535)));
                bus2.filter_i[(r*2+c)*16 +: 16] = 16'(fs[r][c]);
            end
        xs[0][0] = 3;  bus2.ifmap_i[15:0] = 16'd3;
        bus2.start_i = 1'b1;
        tick();
        bus2.start_i = 1'b0;
        for (int j = 1; j <= 120; j++) begin
            if (bus2.done_o) begin
                lat = j;
                break;
            end
            tick();
        end
        checks++; if (lat !== 65) begin errors++; $display("FAIL sweep_latency got=%0d exp=65", lat); end
        tick();
        for (int orr = 0; orr < 4; orr++)
            for (int oc = 0; oc < 4; oc++) begin
                sum = 0;
                for (int a = 0; a < 2; a++)
                    for (int b = 0; b < 2; b++)
                        sum += longint'(xs[orr+a][oc+b]) * longint'(fs[1-a][1-b]);
                if (sum > 32767) sum = 32767;
                if (sum < -32768) sum = -32768;
`ifdef CONV_SEQ_RELU_EN
                if (sum < 0) sum = 0;
`endif
                exp_v = 16'(sum);
                checks++;
                if (bus2.ofmap_o[(orr*4+oc)*16 +: 16] !== exp_v) begin
                    errors++;
                    $display("FAIL sweep_out%0d_%0d got=%h exp=%h", orr, oc, bus2.ofmap_o[(orr*4+oc)*16 +: 16], exp_v);
                end
            end
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.ifmap_i   = '0;
        bus.filter_i  = '0;
        bus2.start_i  = 1'b0;
        bus2.ifmap_i  = '0;
        bus2.filter_i = '0;
        test_reset();
        test_ones();
        test_flip();
        test_saturation();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
